// File: rtl/rv_mem_pkg.sv
// Shared memory definitions for the fetch stage and its data-memory successor.
// Address helpers take the word width as an argument so they serve any XLEN.
package rv_mem_pkg;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } fetch_rsp_t;

  function automatic logic [63:0] word_index(input logic [63:0] addr, input int xlen);
    return addr / 64'(xlen / 8);
  endfunction

  function automatic logic is_misaligned(input logic [63:0] addr, input int xlen);
    return (addr % 64'(xlen / 8)) != 64'd0;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word RAM with one registered read port and one write port, read-first on collision.
// Contents start as INIT and are never cleared afterwards.
module imem_array
  import rv_mem_pkg::*;
#(
  parameter int               DEPTH = 256,
  parameter int               XLEN  = 32,
  parameter int               IDX_W = $clog2(DEPTH),
  parameter logic [XLEN-1:0]  INIT  = '0
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [XLEN-1:0]  rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [XLEN-1:0]  wr_data
);

  logic [XLEN-1:0] mem [DEPTH] = '{default: INIT};

  // Read and write share the edge; non-blocking updates give the old word on a collision.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/imem_sync.sv
// Synchronous instruction memory: one-entry registered response with valid/ready,
// backpressure, flush, alignment/range faults and a run-time program-load port.
module imem_sync
  import rv_mem_pkg::*;
#(
  parameter int              DEPTH_WORDS = 256,
  parameter int              XLEN        = 32,
  parameter int              ADDR_W      = 32,
  parameter logic [XLEN-1:0] NOP_WORD    = XLEN'(rv_mem_pkg::NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_inst,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [XLEN-1:0]   prog_data
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [63:0]     req_idx;
  logic [63:0]     prog_idx;
  logic            req_fault;
  logic            prog_ok;
  logic            accept;
  logic            rd_en;
  logic            wr_en;
  logic [XLEN-1:0] arr_data;
  logic [XLEN-1:0] rsp_inst_q;
  logic            rsp_from_mem;

  // Index checks use the whole address so large addresses never alias onto low words.
  assign req_idx   = word_index(64'(req_addr), XLEN);
  assign prog_idx  = word_index(64'(prog_addr), XLEN);
  assign req_fault = is_misaligned(64'(req_addr), XLEN) || (req_idx >= 64'(DEPTH_WORDS));
  assign prog_ok   = !is_misaligned(64'(prog_addr), XLEN) && (prog_idx < 64'(DEPTH_WORDS));

  assign req_ready = !rsp_valid || rsp_ready || flush;
  assign accept    = req_valid && req_ready;
  assign rd_en     = accept && !req_fault && !rst;
  assign wr_en     = prog_we && prog_ok && !rst;

  imem_array #(
    .DEPTH (DEPTH_WORDS),
    .XLEN  (XLEN),
    .IDX_W (IDX_W),
    .INIT  (NOP_WORD)
  ) u_array (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_idx  (req_idx[IDX_W-1:0]),
    .rd_data (arr_data),
    .wr_en   (wr_en),
    .wr_idx  (prog_idx[IDX_W-1:0]),
    .wr_data (prog_data)
  );

  // The array's read register holds good words; faults and reset select the local NOP register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_addr     <= '0;
      rsp_err      <= 1'b0;
      rsp_inst_q   <= NOP_WORD;
      rsp_from_mem <= 1'b0;
    end else if (accept) begin
      rsp_valid    <= 1'b1;
      rsp_addr     <= req_addr;
      rsp_err      <= req_fault;
      rsp_from_mem <= !req_fault;
      if (req_fault) begin
        rsp_inst_q <= NOP_WORD;
      end
    end else if (flush || (rsp_valid && rsp_ready)) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_inst = rsp_from_mem ? arr_data : rsp_inst_q;

endmodule
